// File: rtl/axi_bridge_nch_if.sv
// AXI3 master-port bundle for axi_bridge_nch.
//   master : the bridge side (drives AR/AW/W, rready, bready)
//   slave  : the memory / interconnect side
// Widths are fixed by the AXI3 pins of core_top (4-bit ids, 32-bit data).
interface axi_bridge_nch_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_bridge_nch.sv
// axi_bridge_nch: NCH read channels + one write channel onto one AXI3 master.
//   aclk, aresetn        clock, async active-low reset
//   flush_i              squash all in-flight reads (their data is dropped)
//   rd_req_i/addr/size   per-channel read request, held until rd_addr_ok_o
//   rd_addr_ok_o         one-hot grant pulse (combinational)
//   rd_data_ok_o/rd_data_o  registered one-hot read-return pulse + shared data
//   wr_*_i               write request, held until wr_addr_ok_o
//   wr_addr_ok_o, wr_ok_o   write accepted / write response received
//   m_axi                AXI3 master port (axi_bridge_nch_if.master)
// Reads are tagged arid = channel index; writes use id NCH.
// Build option: RR_ARB_EN selects round-robin arbitration (default: fixed
// priority, lowest channel wins).

// Per-channel outstanding / discard bookkeeping.
module axi_bridge_nch_ch #(
  parameter int MAX_OUTS = 2,
  parameter int CNT_W    = 3
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic grant_i,
  input  logic ret_i,
  input  logic flush_i,
  output logic full_o,
  output logic deliver_o
);
  logic [CNT_W-1:0] out_q, out_d, disc_q, disc_d;

  always_comb begin
    out_d = out_q;
    if (grant_i && !ret_i)      out_d = out_q + 1'b1;
    else if (!grant_i && ret_i) out_d = out_q - 1'b1;
    disc_d = disc_q;
    // Everything still in flight after this cycle belongs to squashed work.
    if (flush_i)                       disc_d = out_d;
    else if (ret_i && disc_q != '0)    disc_d = disc_q - 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  assign full_o    = (out_q >= CNT_W'(MAX_OUTS));
  assign deliver_o = ret_i && (disc_q == '0) && !flush_i;
endmodule

module axi_bridge_nch #(
  parameter int NCH      = 2,
  parameter int MAX_OUTS = 2,
  parameter int CNT_W    = 3
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 flush_i,
  input  logic [NCH-1:0]       rd_req_i,
  input  logic [NCH-1:0][31:0] rd_addr_i,
  input  logic [NCH-1:0][2:0]  rd_size_i,
  output logic [NCH-1:0]       rd_addr_ok_o,
  output logic [NCH-1:0]       rd_data_ok_o,
  output logic [31:0]          rd_data_o,
  input  logic                 wr_req_i,
  input  logic [31:0]          wr_addr_i,
  input  logic [2:0]           wr_size_i,
  input  logic [3:0]           wr_wstrb_i,
  input  logic [31:0]          wr_data_i,
  output logic                 wr_addr_ok_o,
  output logic                 wr_ok_o,
  axi_bridge_nch_if.master     m_axi
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic       {AR_IDLE, AR_BUSY} ar_st_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_st_e;

  // run_q keeps every handshake output low until the first edge after reset.
  logic run_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  ar_st_e ar_q, ar_d;
  w_st_e  w_q, w_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;

  logic [NCH-1:0] elig, full, haz, grant, ret, deliver;
  logic [NCH-1:0] rd_data_ok_q;
  logic [31:0]    rd_data_q;
  logic           pick_vld, ar_go;
  logic [CH_W-1:0] pick_idx;
  int             base, j;

  // ---------------- per-channel state ----------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Read-after-write: a read to the word being written waits for the B beat.
    assign haz[i]   = (w_q != W_IDLE) && (rd_addr_i[i][31:2] == waddr_q[31:2]);
    assign elig[i]  = rd_req_i[i] && !full[i] && !haz[i];
    assign grant[i] = ar_go && (pick_idx == CH_W'(i));
    assign ret[i]   = m_axi.rvalid && run_q && (m_axi.rid == 4'(i));

    axi_bridge_nch_ch #(.MAX_OUTS(MAX_OUTS), .CNT_W(CNT_W)) u_ch (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .grant_i   (grant[i]),
      .ret_i     (ret[i]),
      .flush_i   (flush_i),
      .full_o    (full[i]),
      .deliver_o (deliver[i])
    );
  end

  // ---------------- arbitration ----------------
`ifdef RR_ARB_EN
  logic [CH_W-1:0] ptr_q;
  assign base = (int'(ptr_q) == NCH-1) ? 0 : int'(ptr_q) + 1;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   ptr_q <= CH_W'(NCH-1);
    else if (ar_go) ptr_q <= pick_idx;
  end
`else
  assign base = 0;
`endif

  // Scan from the farthest slot back toward base so the last hit, i.e. the
  // eligible channel closest to base, wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int k = NCH-1; k >= 0; k--) begin
      j = base + k;
      if (j >= NCH) j = j - NCH;
      if (elig[CH_W'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = CH_W'(j);
      end
    end
  end

  // ---------------- AR FSM ----------------
  assign ar_go = (ar_q == AR_IDLE) && run_q && pick_vld && !flush_i;

  always_comb begin
    ar_d     = ar_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    case (ar_q)
      AR_IDLE: if (ar_go) begin
        arid_d   = 4'(pick_idx);
        araddr_d = rd_addr_i[pick_idx];
        arsize_d = rd_size_i[pick_idx];
        ar_d     = AR_BUSY;
      end
      AR_BUSY: if (m_axi.arready) ar_d = AR_IDLE;
      default: ar_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_q     <= AR_IDLE;
      arid_q   <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
    end else begin
      ar_q     <= ar_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
    end
  end

  assign rd_addr_ok_o = grant;

  // ---------------- R return ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_data_ok_q <= '0;
      rd_data_q    <= '0;
    end else begin
      rd_data_ok_q <= deliver;
      if (|deliver) rd_data_q <= m_axi.rdata;
    end
  end

  assign rd_data_ok_o = rd_data_ok_q & {NCH{!flush_i}};
  assign rd_data_o    = rd_data_q;

  // ---------------- write FSM ----------------
  always_comb begin
    w_d          = w_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wsize_d      = wsize_q;
    wstrb_d      = wstrb_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    wr_addr_ok_o = 1'b0;
    wr_ok_o      = 1'b0;
    case (w_q)
      W_IDLE: if (run_q && wr_req_i) begin
        wr_addr_ok_o = 1'b1;
        waddr_d      = wr_addr_i;
        wdata_d      = wr_data_i;
        wsize_d      = wr_size_i;
        wstrb_d      = wr_wstrb_i;
        aw_pend_d    = 1'b1;
        w_pend_d     = 1'b1;
        w_d          = W_ADDR;
      end
      W_ADDR: begin
        if (m_axi.awready) aw_pend_d = 1'b0;
        if (m_axi.wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) w_d = W_RESP;
      end
      W_RESP: if (m_axi.bvalid) begin
        wr_ok_o = 1'b1;
        w_d     = W_IDLE;
      end
      default: w_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_q       <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wsize_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      w_q       <= w_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wsize_q   <= wsize_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  // ---------------- AXI pins ----------------
  assign m_axi.arid    = arid_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = 4'd0;
  assign m_axi.arsize  = arsize_q;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 2'b00;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arvalid = (ar_q == AR_BUSY);
  assign m_axi.rready  = run_q;

  assign m_axi.awid    = 4'(NCH);
  assign m_axi.awaddr  = waddr_q;
  assign m_axi.awlen   = 4'd0;
  assign m_axi.awsize  = wsize_q;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 2'b00;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awvalid = aw_pend_q;

  assign m_axi.wid     = 4'(NCH);
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = w_pend_q;
  assign m_axi.bready  = run_q;

  // Response codes and ids on B are not acted upon.
  logic unused_axi;
  assign unused_axi = ^{m_axi.rresp, m_axi.rlast, m_axi.bid, m_axi.bresp};
endmodule

// File: tb/tb_axi_bridge_nch.sv
// Directed bench for axi_bridge_nch (NCH=2, MAX_OUTS=2): a cycle table for the
// basic read and contention, then hand sequences for the outstanding limit,
// flush, RAW hazard and asynchronous reset.
module tb_axi_bridge_nch;
  logic aclk = 1'b0, aresetn = 1'b0, flush = 1'b0;
  logic [1:0]       rd_req = '0;
  logic [1:0][31:0] rd_addr = '0;
  logic [1:0][2:0]  rd_size = {3'd2, 3'd2};
  logic [1:0]       rd_addr_ok, rd_data_ok;
  logic [31:0]      rd_data;
  logic             wr_req = 1'b0;
  logic [31:0]      wr_addr = '0, wr_data = '0;
  logic [2:0]       wr_size = 3'd2;
  logic [3:0]       wr_wstrb = 4'hf;
  logic             wr_addr_ok, wr_ok;
  int n_vec = 0, n_err = 0;

  axi_bridge_nch_if bus();

  axi_bridge_nch #(.NCH(2), .MAX_OUTS(2), .CNT_W(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush_i(flush),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_size_i(rd_size),
    .rd_addr_ok_o(rd_addr_ok), .rd_data_ok_o(rd_data_ok), .rd_data_o(rd_data),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_size_i(wr_size),
    .wr_wstrb_i(wr_wstrb), .wr_data_i(wr_data),
    .wr_addr_ok_o(wr_addr_ok), .wr_ok_o(wr_ok),
    .m_axi(bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic        ary, rv;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  e_aok;
    logic        e_arv;
    logic [3:0]  e_arid;
    logic [31:0] e_araddr;
    logic [1:0]  e_dok;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0;
    bus.rresp = '0; bus.rlast = 1'b1; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = '0;

    // basic read
    tbl[0]  = '{2'b01, 32'h1C000000, 0, 1, 0, 0, 0,  2'b01, 0, 0, 0, 2'b00, 0};
    tbl[1]  = '{2'b00, 32'h1C000000, 0, 1, 0, 0, 0,  2'b00, 1, 0, 32'h1C000000, 2'b00, 0};
    tbl[2]  = '{2'b00, 32'h1C000000, 0, 1, 0, 0, 0,  2'b00, 0, 0, 0, 2'b00, 0};
    tbl[3]  = '{2'b00, 32'h1C000000, 0, 1, 0, 0, 0,  2'b00, 0, 0, 0, 2'b00, 0};
    tbl[4]  = '{2'b00, 32'h1C000000, 0, 1, 1, 0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 2'b00, 0};
    tbl[5]  = '{2'b00, 32'h1C000000, 0, 1, 0, 0, 0,  2'b00, 0, 0, 0, 2'b01, 32'hDEADBEEF};
    tbl[6]  = '{2'b00, 32'h1C000000, 0, 1, 0, 0, 0,  2'b00, 0, 0, 0, 2'b00, 0};
    // contention, rd_req=11 held; each return arrives alongside the next grant
    tbl[7]  = '{2'b11, 32'h100, 32'h200, 1, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 0};
    tbl[8]  = '{2'b11, 32'h100, 32'h200, 1, 0, 0, 0, 2'b00, 1, 0, 32'h100, 2'b00, 0};
`ifdef RR_ARB_EN
    tbl[9]  = '{2'b11, 32'h100, 32'h200, 1, 1, 0, 32'h11111111, 2'b10, 0, 0, 0, 2'b00, 0};
    tbl[10] = '{2'b11, 32'h100, 32'h200, 1, 0, 0, 0, 2'b00, 1, 1, 32'h200, 2'b01, 32'h11111111};
    tbl[11] = '{2'b11, 32'h100, 32'h200, 1, 1, 1, 32'h22222222, 2'b01, 0, 0, 0, 2'b00, 0};
    tbl[12] = '{2'b00, 32'h100, 32'h200, 1, 0, 0, 0, 2'b00, 1, 0, 32'h100, 2'b10, 32'h22222222};
`else
    tbl[9]  = '{2'b11, 32'h100, 32'h200, 1, 1, 0, 32'h11111111, 2'b01, 0, 0, 0, 2'b00, 0};
    tbl[10] = '{2'b11, 32'h100, 32'h200, 1, 0, 0, 0, 2'b00, 1, 0, 32'h100, 2'b01, 32'h11111111};
    tbl[11] = '{2'b11, 32'h100, 32'h200, 1, 1, 0, 32'h22222222, 2'b01, 0, 0, 0, 2'b00, 0};
    tbl[12] = '{2'b00, 32'h100, 32'h200, 1, 0, 0, 0, 2'b00, 1, 0, 32'h100, 2'b01, 32'h22222222};
`endif
    tbl[13] = '{2'b00, 32'h100, 32'h200, 1, 1, 0, 32'h33333333, 2'b00, 0, 0, 0, 2'b00, 0};
    tbl[14] = '{2'b00, 32'h100, 32'h200, 1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 32'h33333333};
    tbl[15] = '{2'b00, 32'h100, 32'h200, 1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0};

    // ---- reset state ----
    #12;
    chk("rst arvalid", 32'(bus.arvalid), 0);
    chk("rst awvalid", 32'(bus.awvalid), 0);
    chk("rst rready",  32'(bus.rready), 0);
    chk("rst bready",  32'(bus.bready), 0);
    chk("rst dok",     32'(rd_data_ok), 0);
    @(negedge aclk); aresetn = 1'b1;
    #1 chk("rel rready early", 32'(bus.rready), 0);

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      @(negedge aclk);
      rd_req = tbl[i].req; rd_addr[0] = tbl[i].a0; rd_addr[1] = tbl[i].a1;
      bus.arready = tbl[i].ary; bus.rvalid = tbl[i].rv;
      bus.rid = tbl[i].rid; bus.rdata = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d aok", i), 32'(rd_addr_ok), 32'(tbl[i].e_aok));
      chk($sformatf("v%0d arvalid", i), 32'(bus.arvalid), 32'(tbl[i].e_arv));
      if (tbl[i].e_arv) begin
        chk($sformatf("v%0d arid", i), 32'(bus.arid), 32'(tbl[i].e_arid));
        chk($sformatf("v%0d araddr", i), bus.araddr, tbl[i].e_araddr);
      end
      chk($sformatf("v%0d dok", i), 32'(rd_data_ok), 32'(tbl[i].e_dok));
      if (|tbl[i].e_dok) chk($sformatf("v%0d rdata", i), rd_data, tbl[i].e_data);
      if (i == 0) chk("v0 rready", 32'(bus.rready), 1);
    end
    bus.rvalid = 1'b0;

    // ---- outstanding limit on ch1 ----
    @(negedge aclk); rd_req = 2'b10; rd_addr[1] = 32'h300; bus.arready = 1'b1;
    #1 chk("lim g1", 32'(rd_addr_ok), 2'b10);
    @(negedge aclk); #1 chk("lim busy1", 32'(bus.arvalid), 1);
    @(negedge aclk); #1 chk("lim g2", 32'(rd_addr_ok), 2'b10);
    @(negedge aclk); #1 chk("lim busy2", 32'(bus.arvalid), 1);
    @(negedge aclk); #1 chk("lim hold a", 32'(rd_addr_ok), 0);
    @(negedge aclk); #1 chk("lim hold b", 32'(rd_addr_ok), 0);
    @(negedge aclk); bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h44444444;
    #1 chk("lim hold c", 32'(rd_addr_ok), 0);
    @(negedge aclk); bus.rvalid = 1'b0;
    #1 chk("lim g3", 32'(rd_addr_ok), 2'b10);
    chk("lim dok1", 32'(rd_data_ok), 2'b10);
    chk("lim data1", rd_data, 32'h44444444);
    @(negedge aclk); rd_req = 2'b00; #1 chk("lim busy3", 32'(bus.arvalid), 1);
    @(negedge aclk); bus.rvalid = 1'b1; bus.rdata = 32'h55555555;
    @(negedge aclk); bus.rdata = 32'h66666666;
    #1 chk("lim data2", rd_data, 32'h55555555);
    @(negedge aclk); bus.rvalid = 1'b0;
    #1 chk("lim dok3", 32'(rd_data_ok), 2'b10);
    chk("lim data3", rd_data, 32'h66666666);

    // ---- flush with two reads outstanding on ch0 ----
    @(negedge aclk); rd_req = 2'b01; rd_addr[0] = 32'h400;
    #1 chk("fl g1", 32'(rd_addr_ok), 2'b01);
    @(negedge aclk);
    @(negedge aclk); #1 chk("fl g2", 32'(rd_addr_ok), 2'b01);
    @(negedge aclk); rd_req = 2'b10; rd_addr[1] = 32'h500;
    @(negedge aclk); flush = 1'b1;
    #1 chk("fl no grant", 32'(rd_addr_ok), 0);
    @(negedge aclk); flush = 1'b0; rd_req = 2'b00;
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hAAAAAAAA;
    @(negedge aclk); bus.rdata = 32'hBBBBBBBB;
    #1 chk("fl drop1", 32'(rd_data_ok), 0);
    @(negedge aclk); bus.rvalid = 1'b0;
    #1 chk("fl drop2", 32'(rd_data_ok), 0);
    @(negedge aclk); rd_req = 2'b01;
    #1 chk("fl g3", 32'(rd_addr_ok), 2'b01);
    @(negedge aclk); rd_req = 2'b00;
    @(negedge aclk); bus.rvalid = 1'b1; bus.rdata = 32'hCCCCCCCC;
    @(negedge aclk); bus.rvalid = 1'b0;
    #1 chk("fl dok new", 32'(rd_data_ok), 2'b01);
    chk("fl data new", rd_data, 32'hCCCCCCCC);

    // ---- RAW hazard: write 0x800, read ch1 at 0x802 ----
    @(negedge aclk); wr_req = 1'b1; wr_addr = 32'h800; wr_data = 32'h12345678;
    #1 chk("raw wr_addr_ok", 32'(wr_addr_ok), 1);
    @(negedge aclk); wr_req = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
    rd_req = 2'b10; rd_addr[1] = 32'h802;
    #1 chk("raw awvalid", 32'(bus.awvalid), 1);
    chk("raw wvalid", 32'(bus.wvalid), 1);
    chk("raw awaddr", bus.awaddr, 32'h800);
    chk("raw blk a", 32'(rd_addr_ok), 0);
    @(negedge aclk); #1 chk("raw aw done", 32'(bus.awvalid), 0);
    chk("raw blk b", 32'(rd_addr_ok), 0);
    @(negedge aclk); #1 chk("raw blk c", 32'(rd_addr_ok), 0);
    @(negedge aclk); bus.bvalid = 1'b1;
    #1 chk("raw wr_ok", 32'(wr_ok), 1);
    chk("raw blk d", 32'(rd_addr_ok), 0);
    @(negedge aclk); bus.bvalid = 1'b0;
    #1 chk("raw wr_ok end", 32'(wr_ok), 0);
    chk("raw grant", 32'(rd_addr_ok), 2'b10);
    @(negedge aclk); rd_req = 2'b00;
    @(negedge aclk); bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h77777777;
    @(negedge aclk); bus.rvalid = 1'b0;
    #1 chk("raw dok", 32'(rd_data_ok), 2'b10);

    // ---- asynchronous reset with arvalid and awvalid pending ----
    @(negedge aclk); bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    rd_req = 2'b01; rd_addr[0] = 32'h600; wr_req = 1'b1; wr_addr = 32'h900;
    #1 chk("ar pre grant", 32'(rd_addr_ok), 2'b01);
    @(negedge aclk); wr_req = 1'b0;
    #1 chk("ar pre arvalid", 32'(bus.arvalid), 1);
    chk("ar pre awvalid", 32'(bus.awvalid), 1);
    #2 aresetn = 1'b0;
    #1 chk("ar arvalid", 32'(bus.arvalid), 0);
    chk("ar awvalid", 32'(bus.awvalid), 0);
    chk("ar wvalid", 32'(bus.wvalid), 0);
    chk("ar rready", 32'(bus.rready), 0);
    chk("ar bready", 32'(bus.bready), 0);
    chk("ar aok", 32'(rd_addr_ok), 0);
    @(negedge aclk); rd_req = 2'b00; aresetn = 1'b1;
    @(negedge aclk);
    #1 chk("ar post rready", 32'(bus.rready), 1);
    chk("ar post bready", 32'(bus.bready), 1);
    chk("ar post arvalid", 32'(bus.arvalid), 0);
    chk("ar post awvalid", 32'(bus.awvalid), 0);
    @(negedge aclk); rd_req = 2'b01; rd_addr[0] = 32'h700; bus.arready = 1'b1;
    #1 chk("ar post grant", 32'(rd_addr_ok), 2'b01);
    @(negedge aclk); rd_req = 2'b00;
    #1 chk("ar post araddr", bus.araddr, 32'h700);
    @(negedge aclk); bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h88888888;
    @(negedge aclk); bus.rvalid = 1'b0;
    #1 chk("ar post dok", 32'(rd_data_ok), 2'b01);
    chk("ar post data", rd_data, 32'h88888888);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
